// File: rtl/decode_issue_stage_pkg.sv
// Shared constants and types for the decode/issue stage: opcodes, length codes, issue FSM states.
package decode_issue_stage_pkg;

  localparam int unsigned PARCEL_WIDTH = 16;
  localparam int unsigned INSTR_WIDTH  = 32;

  localparam logic [1:0] INST_LEN_NONE = 2'b00;
  localparam logic [1:0] INST_LEN_16   = 2'b01;
  localparam logic [1:0] INST_LEN_32   = 2'b10;

  localparam logic [1:0] C_Q0 = 2'b00;
  localparam logic [1:0] C_Q1 = 2'b01;
  localparam logic [1:0] C_Q2 = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic                   illegal;
  } rvc_result_t;

  // Compressed 3-bit register field maps onto x8..x15.
  function automatic logic [4:0] creg(input logic [2:0] r);
    return {2'b01, r};
  endfunction

  function automatic logic [11:0] sext6(input logic [5:0] v);
    return {{6{v[5]}}, v};
  endfunction

endpackage

// File: rtl/decode_issue_stage_rvc_expander.sv
// Combinational RV32C -> RV32I expander. Reserved, FP and RV64-only encodings flag illegal;
// illegal parcels pass through zero-extended.
module decode_issue_stage_rvc_expander
  import decode_issue_stage_pkg::*;
(
  input  logic [PARCEL_WIDTH-1:0] parcel,
  output rvc_result_t             result_c
);

  logic [15:0] p;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs2;
  logic [4:0]  rdp;
  logic [4:0]  rs1p;
  logic [5:0]  imm6;

  assign p    = parcel;
  assign f3   = p[15:13];
  assign rd   = p[11:7];
  assign rs2  = p[6:2];
  assign rdp  = creg(p[4:2]);
  assign rs1p = creg(p[9:7]);
  assign imm6 = {p[12], p[6:2]};

  always_comb begin
    result_c.instr   = {16'h0000, p};
    result_c.illegal = 1'b0;
    case (p[1:0])
      C_Q0: begin
        case (f3)
          3'b000: begin
            // c.addi4spn; zero immediate (including the all-zero parcel) is reserved
            if ({p[10:7], p[12:11], p[5], p[6]} == 8'h00) result_c.illegal = 1'b1;
            else result_c.instr = {2'b00, p[10:7], p[12:11], p[5], p[6], 2'b00,
                                   5'd2, 3'b000, rdp, OP_IMM};
          end
          3'b010: result_c.instr = {5'b0, p[5], p[12:10], p[6], 2'b00, rs1p, 3'b010, rdp, OP_LOAD};
          3'b110: result_c.instr = {5'b0, p[5], p[12], rdp, rs1p, 3'b010, p[11:10], p[6], 2'b00,
                                    OP_STORE};
          default: result_c.illegal = 1'b1;
        endcase
      end
      C_Q1: begin
        case (f3)
          3'b000: result_c.instr = {sext6(imm6), rd, 3'b000, rd, OP_IMM};
          3'b001, 3'b101: result_c.instr = {p[12], p[8], p[10:9], p[6], p[7], p[2], p[11], p[5:3],
                                            p[12], {8{p[12]}}, (f3[2] ? 5'd0 : 5'd1), OP_JAL};
          3'b010: result_c.instr = {sext6(imm6), 5'd0, 3'b000, rd, OP_IMM};
          3'b011: begin
            if (rd == 5'd2) begin
              if ({p[12], p[4:3], p[5], p[2], p[6]} == 6'h00) result_c.illegal = 1'b1;
              else result_c.instr = {{3{p[12]}}, p[4:3], p[5], p[2], p[6], 4'b0000,
                                     5'd2, 3'b000, 5'd2, OP_IMM};
            end else begin
              if (imm6 == 6'h00) result_c.illegal = 1'b1;
              else result_c.instr = {{15{p[12]}}, p[6:2], rd, OP_LUI};
            end
          end
          3'b100: begin
            case (p[11:10])
              2'b00, 2'b01: begin
                if (p[12]) result_c.illegal = 1'b1;
                else result_c.instr = {1'b0, p[10], 5'b0, p[6:2], rs1p, 3'b101, rs1p, OP_IMM};
              end
              2'b10: result_c.instr = {sext6(imm6), rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                // p[12]=1 selects the RV64-only subw/addw group
                if (p[12]) result_c.illegal = 1'b1;
                else begin
                  case (p[6:5])
                    2'b00:   result_c.instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_OP};
                    2'b01:   result_c.instr = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_OP};
                    2'b10:   result_c.instr = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_OP};
                    default: result_c.instr = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_OP};
                  endcase
                end
              end
            endcase
          end
          default: result_c.instr = {p[12], {3{p[12]}}, p[6:5], p[2], 5'd0, rs1p,
                                     {2'b00, f3[0]}, p[11:10], p[4:3], p[12], OP_BRANCH};
        endcase
      end
      C_Q2: begin
        case (f3)
          3'b000: begin
            if (p[12]) result_c.illegal = 1'b1;
            else result_c.instr = {7'b0, p[6:2], rd, 3'b001, rd, OP_IMM};
          end
          3'b010: begin
            if (rd == 5'd0) result_c.illegal = 1'b1;
            else result_c.instr = {4'b0, p[3:2], p[12], p[6:4], 2'b00, 5'd2, 3'b010, rd, OP_LOAD};
          end
          3'b100: begin
            if (!p[12]) begin
              if (rs2 != 5'd0) result_c.instr = {7'b0, rs2, 5'd0, 3'b000, rd, OP_OP};
              else if (rd == 5'd0) result_c.illegal = 1'b1;
              else result_c.instr = {12'h000, rd, 3'b000, 5'd0, OP_JALR};
            end else begin
              if (rs2 != 5'd0) result_c.instr = {7'b0, rs2, rd, 3'b000, rd, OP_OP};
              else if (rd == 5'd0) result_c.instr = INSTR_EBREAK;
              else result_c.instr = {12'h000, rd, 3'b000, 5'd1, OP_JALR};
            end
          end
          3'b110: result_c.instr = {4'b0, p[8:7], p[12], rs2, 5'd2, 3'b010, p[11:9], 2'b00, OP_STORE};
          default: result_c.illegal = 1'b1;
        endcase
      end
      default: result_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: sizes fetched instructions, reports retired length, one-entry issue register.
// Optional RVC expansion is enabled by defining RVC_EXPAND_EN.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  input  logic                  instr_valid_i,
  output logic [1:0]            retired_inst_len_o,
  output logic                  req_o,
  input  logic                  flush_i,
  output logic [WORD_WIDTH-1:0] issue_instr_o,
  output logic [ADDR_WIDTH-1:0] issue_addr_o,
  output logic                  issue_compressed_o,
  output logic                  issue_illegal_o,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i
);

  issue_state_e          state;
  issue_state_e          state_next;
  logic                  can_load_c;
  logic                  consume_c;
  logic                  is32_c;
  logic [WORD_WIDTH-1:0] instr_c;
  logic                  illegal_c;

  assign can_load_c = (state == ST_EMPTY) | issue_ready_i;
  assign consume_c  = rst_n & instr_valid_i & can_load_c & ~flush_i;
  assign is32_c     = (instr_i[1:0] == 2'b11);

`ifdef RVC_EXPAND_EN
  rvc_result_t rvc_c;

  decode_issue_stage_rvc_expander u_rvc_expander (
    .parcel   (instr_i[PARCEL_WIDTH-1:0]),
    .result_c (rvc_c)
  );

  assign instr_c   = is32_c ? instr_i : WORD_WIDTH'(rvc_c.instr);
  assign illegal_c = ~is32_c & rvc_c.illegal;
`else
  assign instr_c   = is32_c ? instr_i : WORD_WIDTH'(instr_i[PARCEL_WIDTH-1:0]);
  assign illegal_c = ~is32_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // Next state plus the fetch-facing handshake; flush overrides everything.
  always_comb begin
    state_next         = state;
    retired_inst_len_o = INST_LEN_NONE;
    req_o              = rst_n & (flush_i | ~((state == ST_FULL) & ~issue_ready_i));
    if (consume_c) retired_inst_len_o = is32_c ? INST_LEN_32 : INST_LEN_16;
    case (state)
      ST_EMPTY: if (consume_c) state_next = ST_FULL;
      ST_FULL:  if (!consume_c && issue_ready_i) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
    if (flush_i) state_next = ST_EMPTY;
  end

  assign issue_valid_o = (state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_instr_o      <= '0;
      issue_addr_o       <= '0;
      issue_compressed_o <= 1'b0;
      issue_illegal_o    <= 1'b0;
    end else if (consume_c) begin
      issue_instr_o      <= instr_c;
      issue_addr_o       <= instr_addr_i;
      issue_compressed_o <= ~is32_c;
      issue_illegal_o    <= illegal_c;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomized self-checking bench for decode_issue_stage against a slot-occupancy reference model.
module tb_decode_issue_stage;

  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WW-1:0] instr;
  logic [AW-1:0] instr_addr;
  logic          instr_valid;
  logic [1:0]    ret_len;
  logic          req;
  logic          flush;
  logic [WW-1:0] issue_instr;
  logic [AW-1:0] issue_addr;
  logic          issue_compressed;
  logic          issue_illegal;
  logic          issue_valid;
  logic          issue_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_addr;
  logic        m_comp;
  logic        m_ill;
  logic [31:0] m_w;
  logic        m_il;

  logic [15:0] rvc_tab [5] = '{16'h4505, 16'h852e, 16'h157d, 16'h8082, 16'h0000};

  always #5 clk = ~clk;

  decode_issue_stage #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instr_i            (instr),
    .instr_addr_i       (instr_addr),
    .instr_valid_i      (instr_valid),
    .retired_inst_len_o (ret_len),
    .req_o              (req),
    .flush_i            (flush),
    .issue_instr_o      (issue_instr),
    .issue_addr_o       (issue_addr),
    .issue_compressed_o (issue_compressed),
    .issue_illegal_o    (issue_illegal),
    .issue_valid_o      (issue_valid),
    .issue_ready_i      (issue_ready)
  );

  // Reference: expected 32-bit word for a 16-bit parcel (hand-expanded table when RVC is on).
  function automatic void exp16(input logic [15:0] p, output logic [31:0] w, output logic ill);
    w   = {16'h0000, p};
    ill = 1'b1;
`ifdef RVC_EXPAND_EN
    case (p)
      16'h4505: begin w = 32'h0010_0513; ill = 1'b0; end
      16'h852e: begin w = 32'h00b0_0533; ill = 1'b0; end
      16'h157d: begin w = 32'hfff5_0513; ill = 1'b0; end
      16'h8082: begin w = 32'h0000_8067; ill = 1'b0; end
      default:  begin w = {16'h0000, p}; ill = 1'b1; end
    endcase
`endif
  endfunction

  function automatic logic accept();
    return rst_n && instr_valid && (!m_valid || issue_ready) && !flush;
  endfunction

  function automatic logic [1:0] exp_len();
    if (!accept()) return 2'b00;
    return (instr[1:0] == 2'b11) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic exp_req();
    if (!rst_n) return 1'b0;
    if (flush) return 1'b1;
    return !(m_valid && !issue_ready);
  endfunction

  function automatic logic [66:0] obs();
    return issue_valid ? {1'b1, issue_instr, issue_addr, issue_compressed, issue_illegal} : 67'd0;
  endfunction

  function automatic logic [66:0] expv();
    return m_valid ? {1'b1, m_instr, m_addr, m_comp, m_ill} : 67'd0;
  endfunction

  // Slot model: holds whatever fetch handed over until downstream takes it or a flush kills it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_instr <= '0; m_addr <= '0; m_comp <= 1'b0; m_ill <= 1'b0;
    end else if (accept()) begin
      m_valid <= 1'b1;
      m_addr  <= instr_addr;
      if (instr[1:0] == 2'b11) begin
        m_instr <= instr; m_comp <= 1'b0; m_ill <= 1'b0;
      end else begin
        exp16(instr[15:0], m_w, m_il);
        m_instr <= m_w; m_comp <= 1'b1; m_ill <= m_il;
      end
    end else if (flush || issue_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic r, input logic f);
    instr_valid = v; instr = i; instr_addr = a; issue_ready = r; flush = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    cycle(); cycle();
    n_cmp++;
    if ({issue_valid, issue_instr, issue_addr, issue_compressed, issue_illegal} !== 67'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    n_cmp++;
    if ({ret_len, req} !== 3'b000) begin
      n_bad++; $display("FAIL reset_handshake: got len=%b req=%b expected 00/0", ret_len, req);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2;
    n_cmp++;
    if (req !== 1'b1) begin n_bad++; $display("FAIL reset_release_req: got %b expected 1", req); end
    cycle();
  endtask

  task automatic test_stream32();
    drive(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    #2;
    n_cmp++;
    if (ret_len !== 2'b10) begin n_bad++; $display("FAIL stream32_len: got %b expected 10", ret_len); end
    cycle();
    n_cmp++;
    if (obs() !== {1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL stream32_issue: got %h expected %h", obs(), {1'b1, 32'h0050_0093, 32'h100, 2'b00});
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    n_cmp++;
    if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL stream32_drain: got %b expected 0", issue_valid); end
  endtask

  task automatic test_rvc();
    logic [31:0] ew;
    logic        eil;
`ifdef RVC_EXPAND_EN
    ew = 32'h0010_0513; eil = 1'b0;
`else
    ew = 32'h0000_4505; eil = 1'b1;
`endif
    drive(1'b1, 32'hdead_4505, 32'h104, 1'b1, 1'b0);
    #2;
    n_cmp++;
    if (ret_len !== 2'b01) begin n_bad++; $display("FAIL rvc_len: got %b expected 01", ret_len); end
    cycle();
    n_cmp++;
    if (obs() !== {1'b1, ew, 32'h104, 1'b1, eil}) begin
      n_bad++; $display("FAIL rvc_issue: got %h expected %h", obs(), {1'b1, ew, 32'h104, 1'b1, eil});
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, {16'h5a5a, rvc_tab[k]}, 32'h200 + 32'(2 * k), 1'b1, 1'b0);
      cycle();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL rvc_table_%0d: got %h expected %h", k, obs(), expv()); end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h0020_8113, 32'h300, 1'b1, 1'b0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0031_8193, 32'h304, 1'b0, 1'b0);
      #2;
      n_cmp++;
      if ({ret_len, req} !== 3'b000) begin
        n_bad++; $display("FAIL bp_stall_%0d: got len=%b req=%b expected 00/0", k, ret_len, req);
      end
      cycle();
      n_cmp++;
      if (obs() !== {1'b1, 32'h0020_8113, 32'h300, 2'b00}) begin
        n_bad++; $display("FAIL bp_hold_%0d: got %h expected %h", k, obs(), {1'b1, 32'h0020_8113, 32'h300, 2'b00});
      end
    end
    issue_ready = 1'b1;
    #2;
    n_cmp++;
    if ({ret_len, req} !== 3'b101) begin
      n_bad++; $display("FAIL bp_release: got len=%b req=%b expected 10/1", ret_len, req);
    end
    cycle();
    n_cmp++;
    if (obs() !== {1'b1, 32'h0031_8193, 32'h304, 2'b00}) begin
      n_bad++; $display("FAIL bp_next: got %h expected %h", obs(), {1'b1, 32'h0031_8193, 32'h304, 2'b00});
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0040_0213, 32'h400, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 32'h0050_0293, 32'h404, 1'b0, 1'b1);
    #2;
    n_cmp++;
    if ({ret_len, req} !== 3'b001) begin
      n_bad++; $display("FAIL flush_handshake: got len=%b req=%b expected 00/1", ret_len, req);
    end
    cycle();
    n_cmp++;
    if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush_kill: got %b expected 0", issue_valid); end
    drive(1'b1, 32'h1234_0000, 32'h500, 1'b1, 1'b0);
    #2;
    n_cmp++;
    if (ret_len !== 2'b01) begin n_bad++; $display("FAIL zero_parcel_len: got %b expected 01", ret_len); end
    cycle();
    n_cmp++;
    if ({issue_valid, issue_compressed, issue_illegal} !== 3'b111) begin
      n_bad++; $display("FAIL zero_parcel_illegal: got %b expected 111", {issue_valid, issue_compressed, issue_illegal});
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(1, 0) == 1) w = {$urandom(), 2'b11} >> 0;
      else begin
`ifdef RVC_EXPAND_EN
        w = {16'(($urandom())), rvc_tab[$urandom_range(4, 0)]};
`else
        w = $urandom();
        if (w[1:0] == 2'b11) w[1:0] = 2'($urandom_range(2, 0));
`endif
      end
      if (w[1:0] != 2'b11 && ($urandom_range(1, 0) == 1)) w[15:0] = w[15:0];
      drive(($urandom_range(3, 0) != 0), w, $urandom(), ($urandom_range(2, 0) != 0),
            ($urandom_range(19, 0) == 0));
      #2;
      n_cmp++;
      if ({ret_len, req} !== {exp_len(), exp_req()}) begin
        n_bad++; $display("FAIL rand_handshake_%0d: got len=%b req=%b expected %b/%b", k, ret_len, req, exp_len(), exp_req());
      end
      cycle();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL rand_issue_%0d: got %h expected %h", k, obs(), expv()); end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'h0060_0313, 32'h600, 1'b1, 1'b0);
    cycle();
    issue_ready = 1'b0;
    n_cmp++;
    if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL midreset_full: got %b expected 1", issue_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({issue_valid, issue_instr, issue_addr, issue_compressed, issue_illegal, ret_len, req} !== 70'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h len=%b req=%b expected all 0", obs(), ret_len, req);
    end
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_stream32();
    test_rvc();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
